// File: rtl/usb_tx_pkt_seq_if.sv
// Byte-level link between the packet sequencer (master) and the USB serializer (slave).
interface usb_tx_pkt_seq_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx_den;

  modport master (output tx_data, output tx_valid, input tx_ready, input tx_den);
  modport slave  (input tx_data, input tx_valid, output tx_ready, output tx_den);
endinterface

// File: rtl/usb_tx_pkt_seq.sv
// USB packet sequencer: arbitrates handshake vs data requests, feeds PID/payload/CRC16
// bytes to the serializer and enforces an inter-packet gap after the line is released.
module usb_tx_pkt_seq #(
  parameter int unsigned MAX_LEN    = 64,
  parameter int unsigned IPG_CYCLES = 8
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_hs_req,
  input  logic [1:0]       i_hs_pid,
  output logic             o_hs_done,
  input  logic             i_dat_req,
  input  logic             i_dat_toggle,
  input  logic [6:0]       i_dat_len,
  input  logic [7:0]       i_dat_byte,
  output logic             o_dat_rd,
  output logic             o_dat_done,
  output logic             o_busy,
  usb_tx_pkt_seq_if.master tx
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_PID     = 3'd1;
  localparam logic [2:0] S_PAYLOAD = 3'd2;
  localparam logic [2:0] S_CRC_LO  = 3'd3;
  localparam logic [2:0] S_CRC_HI  = 3'd4;
  localparam logic [2:0] S_LAST    = 3'd5;
  localparam logic [2:0] S_EOP     = 3'd6;
  localparam logic [2:0] S_GAP     = 3'd7;

  localparam int unsigned GW = (IPG_CYCLES > 0) ? $clog2(IPG_CYCLES + 1) : 1;

  // Reflected CRC16 (poly 0x8005 -> 0xA001), one byte, LSB first.
  function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] b);
    logic [15:0] c;
    c = crc ^ {8'h00, b};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
    end
    return c;
  endfunction

  logic [2:0]    r_state;
  logic [7:0]    r_pid;
  logic          r_is_dat;
  logic [6:0]    r_len;
  logic [6:0]    r_cnt;
  logic [15:0]   r_crc;
  logic [GW-1:0] r_gap;
  logic          r_hs_done;
  logic          r_dat_done;

  logic       w_grant;
  logic       w_ready;
  logic [6:0] w_len;
  logic [7:0] w_hs_pid;
  logic [7:0] w_tx_data;
  logic       w_tx_valid;

  assign w_ready = tx.tx_ready;
  // A done pulse blocks the grant so the finishing requester can drop its request.
  assign w_grant = (r_state == S_IDLE) && !r_hs_done && !r_dat_done && (i_hs_req || i_dat_req);
  assign w_len   = (32'(i_dat_len) > MAX_LEN) ? 7'(MAX_LEN) : i_dat_len;

  always_comb begin
    case (i_hs_pid)
      2'b00:   w_hs_pid = 8'hD2;
      2'b01:   w_hs_pid = 8'h5A;
      default: w_hs_pid = 8'h1E;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= S_IDLE;
      r_pid      <= 8'h00;
      r_is_dat   <= 1'b0;
      r_len      <= 7'd0;
      r_cnt      <= 7'd0;
      r_crc      <= 16'hFFFF;
      r_gap      <= '0;
      r_hs_done  <= 1'b0;
      r_dat_done <= 1'b0;
    end else begin
      r_hs_done  <= 1'b0;
      r_dat_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_grant) begin
            r_state <= S_PID;
            r_crc   <= 16'hFFFF;
            r_cnt   <= 7'd0;
            if (i_hs_req) begin
              r_is_dat <= 1'b0;
              r_pid    <= w_hs_pid;
              r_len    <= 7'd0;
            end else begin
              r_is_dat <= 1'b1;
              r_pid    <= i_dat_toggle ? 8'h4B : 8'hC3;
              r_len    <= w_len;
            end
          end
        end
        S_PID: begin
          if (w_ready) begin
            if (!r_is_dat)          r_state <= S_LAST;
            else if (r_len == 7'd0) r_state <= S_CRC_LO;
            else                    r_state <= S_PAYLOAD;
          end
        end
        S_PAYLOAD: begin
          if (w_ready) begin
            r_crc <= crc16_byte(r_crc, i_dat_byte);
            r_cnt <= r_cnt + 7'd1;
            if (r_cnt + 7'd1 == r_len) r_state <= S_CRC_LO;
          end
        end
        S_CRC_LO: if (w_ready) r_state <= S_CRC_HI;
        S_CRC_HI: if (w_ready) r_state <= S_LAST;
        // The ready seen in LAST means the final byte has left the shifter.
        S_LAST:   if (w_ready) r_state <= S_EOP;
        S_EOP: begin
          if (!tx.tx_den) begin
            r_state <= S_GAP;
            r_gap   <= GW'(IPG_CYCLES);
          end
        end
        S_GAP: begin
          if (r_gap == '0) begin
            r_state <= S_IDLE;
            if (r_is_dat) r_dat_done <= 1'b1;
            else          r_hs_done  <= 1'b1;
          end else begin
            r_gap <= r_gap - GW'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    w_tx_data  = 8'h00;
    w_tx_valid = 1'b0;
    case (r_state)
      S_PID:     begin w_tx_data = r_pid;       w_tx_valid = 1'b1; end
      S_PAYLOAD: begin w_tx_data = i_dat_byte;  w_tx_valid = 1'b1; end
      S_CRC_LO:  begin w_tx_data = ~r_crc[7:0];  w_tx_valid = 1'b1; end
      S_CRC_HI:  begin w_tx_data = ~r_crc[15:8]; w_tx_valid = 1'b1; end
      S_LAST:    begin w_tx_data = 8'h00;       w_tx_valid = 1'b1; end
      default:   begin w_tx_data = 8'h00;       w_tx_valid = 1'b0; end
    endcase
  end

  assign tx.tx_data  = w_tx_data;
  assign tx.tx_valid = w_tx_valid;
  assign o_dat_rd    = (r_state == S_PAYLOAD) && w_ready;
  assign o_hs_done   = r_hs_done;
  assign o_dat_done  = r_dat_done;
  assign o_busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_usb_tx_pkt_seq.sv
// Directed bench for usb_tx_pkt_seq: a scripted serializer pulses tx_ready and
// captures bytes, which are checked against hand-built PID/payload/CRC16 expectations.
module tb_usb_tx_pkt_seq;
  localparam int unsigned IPG = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic       hs_req, dat_req, dat_toggle;
  logic [1:0] hs_pid;
  logic [6:0] dat_len;
  logic [7:0] dat_byte;
  logic       dat_rd, hs_done, dat_done, busy;

  usb_tx_pkt_seq_if bus ();

  usb_tx_pkt_seq #(.MAX_LEN(64), .IPG_CYCLES(IPG)) dut (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_hs_req     (hs_req),
    .i_hs_pid     (hs_pid),
    .o_hs_done    (hs_done),
    .i_dat_req    (dat_req),
    .i_dat_toggle (dat_toggle),
    .i_dat_len    (dat_len),
    .i_dat_byte   (dat_byte),
    .o_dat_rd     (dat_rd),
    .o_dat_done   (dat_done),
    .o_busy       (busy),
    .tx           (bus)
  );

  always #5 clk = ~clk;

  // Payload source: byte index advances the cycle after each pop.
  logic       pay_clr;
  logic [7:0] pay_base;
  logic [7:0] pidx = 8'd0;
  always @(posedge clk) begin
    if (pay_clr)     pidx <= 8'd0;
    else if (dat_rd) pidx <= pidx + 8'd1;
  end
  assign dat_byte = pidx + pay_base;

  int rd_cnt = 0, rd_bad = 0, hs_cnt = 0, dd_cnt = 0;
  always @(posedge clk) begin
    if (dat_rd) rd_cnt <= rd_cnt + 1;
    if (dat_rd && !bus.tx_ready) rd_bad <= rd_bad + 1;
    if (hs_done) hs_cnt <= hs_cnt + 1;
    if (dat_done) dd_cnt <= dd_cnt + 1;
  end

  int         total = 0, bad = 0;
  logic [7:0] cap [0:127];
  logic       capv[0:127];
  logic [7:0] exp_b[0:127];
  int         exp_n;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Bit-serial reference CRC16/USB over bytes base, base+1, ...; returns inverted value.
  function automatic logic [15:0] crc_ref(input int n, input logic [7:0] base);
    logic [15:0] c;
    logic [7:0]  b;
    logic        fb;
    c = 16'hFFFF;
    for (int i = 0; i < n; i++) begin
      b = base + 8'(i);
      for (int k = 0; k < 8; k++) begin
        fb = c[0] ^ b[k];
        c  = c >> 1;
        if (fb) c = c ^ 16'hA001;
      end
    end
    return ~c;
  endfunction

  task automatic set_exp_data(input logic tog, input int len, input logic [7:0] base);
    int          n;
    logic [15:0] c;
    n = (len > 64) ? 64 : len;
    exp_b[0] = tog ? 8'h4B : 8'hC3;
    for (int i = 0; i < n; i++) exp_b[1 + i] = base + 8'(i);
    c = crc_ref(n, base);
    exp_b[n + 1] = c[7:0];
    exp_b[n + 2] = c[15:8];
    exp_n = n + 3;
  endtask

  task automatic pulse_ready(input int i);
    @(negedge clk);
    cap[i]  = bus.tx_data;
    capv[i] = bus.tx_valid;
    bus.tx_ready = 1'b1;
    @(negedge clk);
    bus.tx_ready = 1'b0;
  endtask

  task automatic clear_payload(input logic [7:0] base);
    pay_base = base;
    pay_clr  = 1'b1;
    @(negedge clk);
    pay_clr  = 1'b0;
  endtask

  // Runs one whole packet from request to done; expectations come from exp_b/exp_n.
  task automatic run_pkt(input string tag, input logic is_dat, input int lat, input int nrd);
    int t, rd0, hs0, dd0;
    rd0 = rd_cnt; hs0 = hs_cnt; dd0 = dd_cnt; t = 0;
    while (bus.tx_valid !== 1'b1 && t < 50) begin @(negedge clk); t++; end
    chk({tag, "/latency"}, t, lat);
    bus.tx_den = 1'b1;
    // Latched fields must ignore these mid-packet changes.
    dat_len    = dat_len + 7'd5;
    dat_toggle = ~dat_toggle;
    hs_pid     = ~hs_pid;
    for (int i = 0; i <= exp_n; i++) pulse_ready(i);
    for (int i = 0; i < exp_n; i++) chk($sformatf("%s/byte%0d", tag, i), cap[i], exp_b[i]);
    chk({tag, "/valid_at_last_ready"}, capv[exp_n], 1'b1);
    chk({tag, "/valid_fall"}, bus.tx_valid, 1'b0);
    repeat (2) @(negedge clk);
    chk({tag, "/busy_in_eop"}, busy, 1'b1);
    bus.tx_den = 1'b0;
    t = 0;
    while (!(hs_done || dat_done) && t < 40) begin @(negedge clk); t++; end
    chk({tag, "/gap_cycles"}, t, IPG + 2);
    chk({tag, "/done_kind"}, is_dat ? dat_done : hs_done, 1'b1);
    if (is_dat) dat_req = 1'b0;
    else        hs_req  = 1'b0;
    @(negedge clk);
    chk({tag, "/done_low"}, hs_done | dat_done, 1'b0);
    chk({tag, "/busy_after_done"}, busy, 1'b0);
    chk({tag, "/dat_done_cnt"}, dd_cnt - dd0, {31'd0, is_dat});
    chk({tag, "/hs_done_cnt"}, hs_cnt - hs0, {31'd0, !is_dat});
    chk({tag, "/dat_rd_cnt"}, rd_cnt - rd0, nrd);
  endtask

  initial begin
    logic [7:0] hs_exp[0:3];
    int         t;
    hs_exp[0] = 8'hD2; hs_exp[1] = 8'h5A; hs_exp[2] = 8'h1E; hs_exp[3] = 8'h1E;
    reset = 1'b1; hs_req = 1'b0; dat_req = 1'b0; dat_toggle = 1'b0;
    hs_pid = 2'b00; dat_len = 7'd0; pay_clr = 1'b1; pay_base = 8'h00;
    bus.tx_ready = 1'b0; bus.tx_den = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset/tx_valid", bus.tx_valid, 1'b0);
    chk("reset/tx_data", bus.tx_data, 8'h00);
    chk("reset/busy", busy, 1'b0);
    chk("reset/dat_rd", dat_rd, 1'b0);
    chk("reset/done", hs_done | dat_done, 1'b0);
    reset = 1'b0; pay_clr = 1'b0;
    @(negedge clk);

    // Handshakes: ACK, NAK, STALL, reserved->STALL.
    for (int p = 0; p < 4; p++) begin
      hs_pid = 2'(p);
      exp_b[0] = hs_exp[p];
      exp_n = 1;
      hs_req = 1'b1;
      run_pkt($sformatf("hs%0d", p), 1'b0, 1, 0);
    end

    // Zero-length DATA0.
    clear_payload(8'h00);
    dat_toggle = 1'b0; dat_len = 7'd0;
    set_exp_data(1'b0, 0, 8'h00);
    dat_req = 1'b1;
    run_pkt("len0", 1'b1, 1, 0);

    // DATA1 with 00 01 02 03.
    clear_payload(8'h00);
    dat_toggle = 1'b1; dat_len = 7'd4;
    set_exp_data(1'b1, 4, 8'h00);
    dat_req = 1'b1;
    run_pkt("len4", 1'b1, 1, 4);

    // Simultaneous requests: handshake first, data fields taken at the later grant.
    clear_payload(8'h10);
    hs_pid = 2'b01; dat_toggle = 1'b0; dat_len = 7'd4;
    exp_b[0] = 8'h5A; exp_n = 1;
    hs_req = 1'b1; dat_req = 1'b1;
    run_pkt("both/hs", 1'b0, 1, 0);
    dat_toggle = 1'b1; dat_len = 7'd3;
    set_exp_data(1'b1, 3, 8'h10);
    run_pkt("both/dat", 1'b1, 1, 3);

    // Reset in the middle of the payload.
    clear_payload(8'h00);
    dat_toggle = 1'b0; dat_len = 7'd4; dat_req = 1'b1;
    t = 0;
    while (bus.tx_valid !== 1'b1 && t < 50) begin @(negedge clk); t++; end
    chk("rst/latency", t, 1);
    bus.tx_den = 1'b1;
    for (int i = 0; i < 3; i++) pulse_ready(i);
    chk("rst/byte1_before", cap[1], 8'h00);
    chk("rst/busy_before", busy, 1'b1);
    reset = 1'b1; dat_req = 1'b0;
    @(negedge clk);
    chk("rst/tx_valid", bus.tx_valid, 1'b0);
    chk("rst/busy", busy, 1'b0);
    chk("rst/tx_data", bus.tx_data, 8'h00);
    reset = 1'b0; bus.tx_den = 1'b0;
    t = dd_cnt;
    repeat (15) @(negedge clk);
    chk("rst/no_done", dd_cnt - t, 0);
    chk("rst/idle", busy, 1'b0);
    clear_payload(8'h20);
    dat_toggle = 1'b1; dat_len = 7'd3;
    set_exp_data(1'b1, 3, 8'h20);
    dat_req = 1'b1;
    run_pkt("after_rst", 1'b1, 1, 3);

    // Oversized length clamps to 64 payload bytes.
    clear_payload(8'h00);
    dat_toggle = 1'b0; dat_len = 7'd100;
    set_exp_data(1'b0, 100, 8'h00);
    chk("clamp/exp_n", exp_n, 67);
    dat_req = 1'b1;
    run_pkt("clamp", 1'b1, 1, 64);

    chk("dat_rd_without_ready", rd_bad, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
